pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and program-flow controller for a 5-stage in-order pipeline.
//   Tracks the destination registers of in-flight instructions (EX, MEM and WB)
//   in a small scoreboard. Stalls decode on a read-after-write hazard. Squashes
//   and redirects fetch on a taken branch. Sequences halt -> drain -> done.
//
// Ports
//   i_clk              clock; all state updates on the rising edge
//   i_rst              synchronous active-high reset
//   i_id_valid         decode stage holds a real instruction
//   i_id_opcode[4:0]   decode-stage opcode
//   i_id_rs/rt[4:0]    decode source register indices
//   i_id_rs/rt_used    corresponding source is read
//   i_id_rd[4:0]       decode destination index
//   i_id_rd_we         decode instruction writes i_id_rd
//   i_ex_branch_taken  branch resolved taken in EX this cycle
//   i_ex_branch_target taken-branch instruction address
//   o_stall            hold PC and IF/ID
//   o_bubble_idex      load a NOP into ID/EX
//   o_flush_ifid       squash IF/ID
//   o_pc_load          redirect fetch to o_pc_target
//   o_pc_target[6:0]   redirect address (0 when no redirect)
//   o_state[1:0]       RUN=0, DRAIN=1, DONE=2
//   o_done             program complete
module pipe_hazard_ctrl #(
    parameter logic [4:0]  HALT_OP      = 5'b11111,
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_id_valid,
    input  logic [4:0] i_id_opcode,
    input  logic [4:0] i_id_rs,
    input  logic [4:0] i_id_rt,
    input  logic       i_id_rs_used,
    input  logic       i_id_rt_used,
    input  logic [4:0] i_id_rd,
    input  logic       i_id_rd_we,
    input  logic       i_ex_branch_taken,
    input  logic [6:0] i_ex_branch_target,
    output logic       o_stall,
    output logic       o_bubble_idex,
    output logic       o_flush_ifid,
    output logic       o_pc_load,
    output logic [6:0] o_pc_target,
    output logic [1:0] o_state,
    output logic       o_done
);

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StDrain = 2'd1,
        StDone  = 2'd2
    } state_t;

    // Counter is 3 bits; out-of-range drain lengths clamp to the widest value.
    localparam logic [2:0] CntInit =
        (DRAIN_CYCLES == 0) ? 3'd0 :
        (DRAIN_CYCLES > 8)  ? 3'd7 : 3'(DRAIN_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_cnt;
    logic [2:0]      w_cnt_nxt;

    // Scoreboard index 0 = EX, 1 = MEM, 2 = WB.
    logic [2:0]      r_sb_v;
    logic [2:0][4:0] r_sb_rd;
    logic            w_ex_v;

    logic            w_rs_hit;
    logic            w_rt_hit;
    logic            w_hazard;
    logic            w_halt_accept;

    // WB is still checked: the register file has no write-through to decode.
    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (r_sb_v[i] && (r_sb_rd[i] == i_id_rs)) w_rs_hit = 1'b1;
            if (r_sb_v[i] && (r_sb_rd[i] == i_id_rt)) w_rt_hit = 1'b1;
        end
        w_hazard = i_id_valid &
                   ((i_id_rs_used & (i_id_rs != 5'd0) & w_rs_hit) |
                    (i_id_rt_used & (i_id_rt != 5'd0) & w_rt_hit));
    end

    // Outputs and next state
    always_comb begin
        o_stall       = 1'b0;
        o_bubble_idex = 1'b0;
        o_flush_ifid  = 1'b0;
        o_pc_load     = 1'b0;
        o_pc_target   = 7'd0;
        o_done        = 1'b0;
        w_halt_accept = 1'b0;
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;

        unique case (r_state)
            StRun: begin
                if (i_ex_branch_taken) begin
                    o_flush_ifid  = 1'b1;
                    o_bubble_idex = 1'b1;
                    o_pc_load     = 1'b1;
                    o_pc_target   = i_ex_branch_target;
                end else if (w_hazard) begin
                    o_stall       = 1'b1;
                    o_bubble_idex = 1'b1;
                end
                w_halt_accept = i_id_valid & (i_id_opcode == HALT_OP) &
                                ~o_stall & ~i_ex_branch_taken;
                if (w_halt_accept) begin
                    w_state_nxt = StDrain;
                    w_cnt_nxt   = CntInit;
                end
            end
            StDrain: begin
                o_bubble_idex = 1'b1;
                if (i_ex_branch_taken) begin
                    // An older branch squashed the halt: resume normal flow.
                    o_flush_ifid = 1'b1;
                    o_pc_load    = 1'b1;
                    o_pc_target  = i_ex_branch_target;
                    w_state_nxt  = StRun;
                    w_cnt_nxt    = 3'd0;
                end else begin
                    o_stall = 1'b1;
                    if (r_cnt == 3'd0) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_cnt_nxt = r_cnt - 3'd1;
                    end
                end
            end
            StDone: begin
                o_stall       = 1'b1;
                o_bubble_idex = 1'b1;
                o_done        = 1'b1;
            end
            default: begin
                w_state_nxt = StRun;
                w_cnt_nxt   = 3'd0;
            end
        endcase

        w_ex_v = i_id_valid & i_id_rd_we & ~o_stall & ~o_flush_ifid & (r_state == StRun);
    end

    assign o_state = r_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StRun;
            r_cnt   <= 3'd0;
            r_sb_v  <= 3'b000;
            r_sb_rd <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_sb_v     <= {r_sb_v[1:0], w_ex_v};
            r_sb_rd[2] <= r_sb_rd[1];
            r_sb_rd[1] <= r_sb_rd[0];
            r_sb_rd[0] <= i_id_rd;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Expected outputs for each cycle are
// queued as the stimulus is driven and popped and compared mid-cycle.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_opcode;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_rs_used;
    logic       id_rt_used;
    logic [4:0] id_rd;
    logic       id_rd_we;
    logic       br_taken;
    logic [6:0] br_target;
    logic       stall;
    logic       bubble;
    logic       flush;
    logic       pc_load;
    logic [6:0] pc_target;
    logic [1:0] state;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic       stall;
        logic       bubble;
        logic       flush;
        logic       pc_load;
        logic [6:0] target;
        logic [1:0] state;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    pipe_hazard_ctrl #(
        .HALT_OP      (5'b11111),
        .DRAIN_CYCLES (4)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_id_valid         (id_valid),
        .i_id_opcode        (id_opcode),
        .i_id_rs            (id_rs),
        .i_id_rt            (id_rt),
        .i_id_rs_used       (id_rs_used),
        .i_id_rt_used       (id_rt_used),
        .i_id_rd            (id_rd),
        .i_id_rd_we         (id_rd_we),
        .i_ex_branch_taken  (br_taken),
        .i_ex_branch_target (br_target),
        .o_stall            (stall),
        .o_bubble_idex      (bubble),
        .o_flush_ifid       (flush),
        .o_pc_load          (pc_load),
        .o_pc_target        (pc_target),
        .o_state            (state),
        .o_done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic s, input logic b, input logic f, input logic pl,
                                input logic [6:0] t, input logic [1:0] st, input logic d);
        exp_t e;
        e.stall   = s;
        e.bubble  = b;
        e.flush   = f;
        e.pc_load = pl;
        e.target  = t;
        e.state   = st;
        e.done    = d;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle();
        id_valid   = 1'b0;
        id_opcode  = 5'd0;
        id_rs      = 5'd0;
        id_rt      = 5'd0;
        id_rs_used = 1'b0;
        id_rt_used = 1'b0;
        id_rd      = 5'd0;
        id_rd_we   = 1'b0;
        br_taken   = 1'b0;
        br_target  = 7'd0;
    endtask

    task automatic instr(input logic [4:0] op, input logic [4:0] rs, input logic rs_u,
                         input logic [4:0] rt, input logic rt_u,
                         input logic [4:0] rd, input logic we);
        id_valid   = 1'b1;
        id_opcode  = op;
        id_rs      = rs;
        id_rs_used = rs_u;
        id_rt      = rt;
        id_rt_used = rt_u;
        id_rd      = rd;
        id_rd_we   = we;
    endtask

    // Queue the expectation for the current cycle, compare mid-cycle, advance.
    task automatic cyc(input string tag, input exp_t e);
        exp_t x;
        exp_q.push_back(e);
        @(negedge clk);
        x = exp_q.pop_front();
        chk({tag, ".stall"},   {7'd0, stall},   {7'd0, x.stall});
        chk({tag, ".bubble"},  {7'd0, bubble},  {7'd0, x.bubble});
        chk({tag, ".flush"},   {7'd0, flush},   {7'd0, x.flush});
        chk({tag, ".pc_load"}, {7'd0, pc_load}, {7'd0, x.pc_load});
        chk({tag, ".target"},  {1'b0, pc_target}, {1'b0, x.target});
        chk({tag, ".state"},   {6'd0, state},   {6'd0, x.state});
        chk({tag, ".done"},    {7'd0, done},    {7'd0, x.done});
        @(posedge clk);
        #1;
    endtask

    exp_t e_zero;
    exp_t e_stall;
    exp_t e_drain;
    exp_t e_done;

    initial begin
        e_zero  = mk(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 1'b0);
        e_stall = mk(1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 2'd0, 1'b0);
        e_drain = mk(1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 2'd1, 1'b0);
        e_done  = mk(1'b1, 1'b1, 1'b0, 1'b0, 7'd0, 2'd2, 1'b1);

        idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("reset", e_zero);

        // RAW on rs: stalls while producer sits in EX, MEM and WB.
        instr(5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        cyc("raw_issue", e_zero);
        instr(5'd2, 5'd3, 1'b1, 5'd0, 1'b0, 5'd9, 1'b0);
        cyc("raw_ex", e_stall);
        cyc("raw_mem", e_stall);
        cyc("raw_wb", e_stall);
        cyc("raw_clear", e_zero);

        // Register 0 never hazards.
        instr(5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
        cyc("r0_issue", e_zero);
        instr(5'd2, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);
        cyc("r0_read", e_zero);

        // rt path; an unused source does not hazard.
        instr(5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        cyc("rt_issue", e_zero);
        instr(5'd2, 5'd0, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
        cyc("rt_unused", e_zero);
        instr(5'd2, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        cyc("rt_mem", e_stall);
        cyc("rt_wb", e_stall);
        cyc("rt_clear", e_zero);

        // Branch overrides a pending hazard.
        instr(5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        cyc("br_issue", e_zero);
        instr(5'd2, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("br_haz", e_stall);
        br_taken  = 1'b1;
        br_target = 7'h2A;
        cyc("br_taken", mk(1'b0, 1'b1, 1'b1, 1'b1, 7'h2A, 2'd0, 1'b0));
        idle();
        cyc("br_after", e_zero);

        // Halt blocked by a hazard, then by a same-cycle branch.
        instr(5'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1);
        cyc("hb_issue", e_zero);
        instr(5'b11111, 5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("hb_haz", e_stall);
        idle();
        cyc("hb_run1", e_zero);
        instr(5'b11111, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        br_taken  = 1'b1;
        br_target = 7'h11;
        cyc("hb_br", mk(1'b0, 1'b1, 1'b1, 1'b1, 7'h11, 2'd0, 1'b0));
        idle();
        cyc("hb_run2", e_zero);

        // Halt -> 4 drain cycles -> DONE held.
        instr(5'b11111, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("halt_acc", e_zero);
        idle();
        for (int i = 0; i < 4; i++) cyc("drain", e_drain);
        for (int i = 0; i < 11; i++) begin
            if (i == 5) instr(5'd2, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            cyc("done_hold", e_done);
        end

        // One-cycle reset from DONE.
        idle();
        rst = 1'b1;
        cyc("rst_in_done", e_done);
        rst = 1'b0;
        instr(5'd2, 5'd3, 1'b1, 5'd7, 1'b1, 5'd0, 1'b0);
        cyc("post_rst", e_zero);

        // Branch during DRAIN returns to RUN.
        instr(5'b11111, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        cyc("halt2_acc", e_zero);
        idle();
        cyc("drain2", e_drain);
        br_taken  = 1'b1;
        br_target = 7'h15;
        cyc("drain_br", mk(1'b0, 1'b1, 1'b1, 1'b1, 7'h15, 2'd1, 1'b0));
        idle();
        cyc("drain_br_run", e_zero);

        // Reset wins over a halt in ID.
        instr(5'b11111, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;
        cyc("rst_prio", e_zero);
        rst = 1'b0;
        idle();
        cyc("rst_prio_run", e_zero);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound in case the stimulus sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
